// File: rtl/func3_select_pkg.sv
// Shared control-unit definitions: instruction-class code layout and the
// mask of classes whose downstream units consume funct3.
package func3_select_pkg;

    localparam int unsigned CODE_W = 10;

    localparam int unsigned IDX_J     = 0;
    localparam int unsigned IDX_JALR  = 1;
    localparam int unsigned IDX_LUI   = 2;
    localparam int unsigned IDX_AUIPC = 3;
    localparam int unsigned IDX_B     = 4;
    localparam int unsigned IDX_R     = 5;
    localparam int unsigned IDX_S     = 6;
    localparam int unsigned IDX_ALU   = 7;
    localparam int unsigned IDX_LOAD  = 8;
    localparam int unsigned IDX_CSR   = 9;

    typedef logic [CODE_W-1:0] code_t;

    // Evaluates to 10'b1010100100; also consumed by the funct7 gate.
    localparam code_t PASS_MASK = code_t'((1 << IDX_LUI) | (1 << IDX_R) |
                                          (1 << IDX_ALU) | (1 << IDX_CSR));

endpackage

// File: rtl/func3_select_onehot_check.sv
// Exactly-one-hot detector, shared by the control-unit gates.
module func3_select_onehot_check #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] vec,
    output logic         onehot
);

    logic [W-1:0] vec_m1;

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign vec_m1 = vec - {{(W-1){1'b0}}, 1'b1};
    assign onehot = (vec != '0) && ((vec & vec_m1) == '0);

endmodule

// File: rtl/func3_select.sv
// FUNC3 gate for the RV32I decoder: forwards funct3 only for classes that
// use it, plus a registered copy and a sticky illegal-class-code flag.
module func3_select
    import func3_select_pkg::*;
#(
    parameter logic [9:0] PASS_MASK = func3_select_pkg::PASS_MASK
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] INSN,
    input  logic [9:0] CODE,
    output logic [2:0] FUNC3,
    output logic [2:0] FUNC3_Q,
    output logic       CODE_ERR
);

    logic       pass;
    logic       code_onehot;
    logic [2:0] func3_q_q, func3_q_d;
    logic       code_err_q, code_err_d;

    // Ternary keeps X/Z on INSN intact for pass-through classes.
    assign pass  = |(CODE & PASS_MASK);
    assign FUNC3 = pass ? INSN : 3'b000;

    func3_select_onehot_check #(
        .W (CODE_W)
    ) u_onehot_check (
        .vec    (CODE),
        .onehot (code_onehot)
    );

    always_comb begin
        func3_q_d  = FUNC3;
        code_err_d = code_err_q | ~code_onehot;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            func3_q_q  <= 3'b000;
            code_err_q <= 1'b0;
        end else begin
            func3_q_q  <= func3_q_d;
            code_err_q <= code_err_d;
        end
    end

    assign FUNC3_Q  = func3_q_q;
    assign CODE_ERR = code_err_q;

endmodule

// File: tb/tb_func3_select.sv
// Directed self-checking bench for func3_select.
module tb_func3_select;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] INSN;
    logic [9:0] CODE;
    logic [2:0] FUNC3;
    logic [2:0] FUNC3_Q;
    logic       CODE_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    func3_select dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .INSN     (INSN),
        .CODE     (CODE),
        .FUNC3    (FUNC3),
        .FUNC3_Q  (FUNC3_Q),
        .CODE_ERR (CODE_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET = 1'b1;
        CODE  = 10'b0000100000;
        INSN  = 3'b111;
        @(posedge CLK); @(posedge CLK); #1;
        n_cmp++;
        if (FUNC3_Q !== 3'b000) begin
            n_bad++; $display("FAIL reset_func3_q got %b want 000", FUNC3_Q);
        end
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL reset_code_err got %b want 0", CODE_ERR);
        end
        n_cmp++;
        if (FUNC3 !== 3'b111) begin
            n_bad++; $display("FAIL reset_func3_comb got %b want 111", FUNC3);
        end
    endtask

    task automatic test_walk_known();
        logic [2:0] exp;
        for (int i = 0; i < 10; i++) begin
            CODE = 10'b0000000001 << i;
            INSN = 3'b101;
            #10;
            exp = (i == 2 || i == 5 || i == 7 || i == 9) ? 3'b101 : 3'b000;
            n_cmp++;
            if (FUNC3 !== exp) begin
                n_bad++; $display("FAIL walk_known bit%0d got %b want %b", i, FUNC3, exp);
            end
        end
    endtask

    task automatic test_walk_x();
        logic [2:0] xval;
        logic [2:0] exp;
        xval = 3'bxxx;
        for (int i = 0; i < 10; i++) begin
            CODE = 10'b0000000001 << i;
            INSN = xval;
            #10;
            exp = (i == 2 || i == 5 || i == 7 || i == 9) ? xval : 3'b000;
            n_cmp++;
            if (FUNC3 !== exp) begin
                n_bad++; $display("FAIL walk_x bit%0d got %b want %b", i, FUNC3, exp);
            end
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 8; v++) begin
            CODE = 10'b0000100000;
            INSN = 3'(v);
            #10;
            n_cmp++;
            if (FUNC3 !== 3'(v)) begin
                n_bad++; $display("FAIL sweep_r insn=%0d got %b want %b", v, FUNC3, 3'(v));
            end
            CODE = 10'b0001000000;
            #10;
            n_cmp++;
            if (FUNC3 !== 3'b000) begin
                n_bad++; $display("FAIL sweep_s insn=%0d got %b want 000", v, FUNC3);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge CLK);
        RESET = 1'b1;
        CODE  = 10'b0010000000;
        INSN  = 3'b110;
        @(posedge CLK); #1;
        n_cmp++;
        if (FUNC3_Q !== 3'b000) begin
            n_bad++; $display("FAIL reg_after_reset got %b want 000", FUNC3_Q);
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if (FUNC3_Q !== 3'b110) begin
            n_bad++; $display("FAIL reg_latency got %b want 110", FUNC3_Q);
        end
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL reg_code_err got %b want 0", CODE_ERR);
        end
    endtask

    task automatic test_code_zero();
        @(negedge CLK);
        CODE = 10'b0000000000;
        INSN = 3'b101;
        #1;
        n_cmp++;
        if (FUNC3 !== 3'b000) begin
            n_bad++; $display("FAIL zero_func3 got %b want 000", FUNC3);
        end
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL zero_err_before_edge got %b want 0", CODE_ERR);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b1) begin
            n_bad++; $display("FAIL zero_err_set got %b want 1", CODE_ERR);
        end
        @(negedge CLK);
        CODE = 10'b0000100000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b1) begin
            n_bad++; $display("FAIL zero_err_sticky got %b want 1", CODE_ERR);
        end
        n_cmp++;
        if (FUNC3_Q !== 3'b101) begin
            n_bad++; $display("FAIL zero_then_r_q got %b want 101", FUNC3_Q);
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL zero_err_cleared got %b want 0", CODE_ERR);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_multi_hot();
        @(negedge CLK);
        CODE = 10'b0000100001;
        INSN = 3'b011;
        #1;
        n_cmp++;
        if (FUNC3 !== 3'b011) begin
            n_bad++; $display("FAIL multi_jr_func3 got %b want 011", FUNC3);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b1) begin
            n_bad++; $display("FAIL multi_jr_err got %b want 1", CODE_ERR);
        end
        n_cmp++;
        if (FUNC3_Q !== 3'b011) begin
            n_bad++; $display("FAIL multi_jr_q got %b want 011", FUNC3_Q);
        end
        @(negedge CLK);
        CODE = 10'b0000010001;
        INSN = 3'b111;
        #1;
        n_cmp++;
        if (FUNC3 !== 3'b000) begin
            n_bad++; $display("FAIL multi_jb_func3 got %b want 000", FUNC3);
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset_wins();
        @(negedge CLK);
        RESET = 1'b1;
        CODE  = 10'b0001000001;
        INSN  = 3'b010;
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL reset_wins_err got %b want 0", CODE_ERR);
        end
        @(negedge CLK);
        RESET = 1'b0;
        CODE  = 10'b1000000000;
        INSN  = 3'b100;
        @(posedge CLK); #1;
        n_cmp++;
        if (CODE_ERR !== 1'b0) begin
            n_bad++; $display("FAIL reset_wins_after got %b want 0", CODE_ERR);
        end
        n_cmp++;
        if (FUNC3_Q !== 3'b100) begin
            n_bad++; $display("FAIL reset_wins_csr_q got %b want 100", FUNC3_Q);
        end
    endtask

    initial begin
        RESET = 1'b1;
        CODE  = 10'b0000100000;
        INSN  = 3'b000;
        test_reset();
        test_walk_known();
        test_walk_x();
        test_sweep();
        test_registered();
        test_code_zero();
        test_multi_hot();
        test_reset_wins();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
